// File: rtl/regbank_pkg.sv
// regbank_pkg -- shared constants and types for the regbank_sb register bank.
// Optional feature macro used by regbank_sb: REGBANK_BYPASS_EN (same-cycle
// write-to-read forwarding of data and busy state).
package regbank_pkg;

  // Default geometry of the bank (matches the original 8x8 decode-stage bank).
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // Reset value of every storage bit; words are built by replication.
  localparam logic RST_BIT = 1'b0;

  // Per-entry busy-bit update chosen by the scoreboard each cycle.
  typedef enum logic [1:0] {
    BSY_HOLD  = 2'd0,
    BSY_CLEAR = 2'd1,
    BSY_SET   = 2'd2
  } busy_op_e;

  // Number of registers addressed by an ADDR_W-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage : regbank_pkg

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard -- one busy bit per architectural register.
// A reservation (instruction issued) sets the bit, a write-back clears it, and
// when both hit the same register in one cycle the new producer wins (bit set).
// Two combinational lookups return either the pre-edge bit or, with BYPASS_EN,
// the value the bit will take at this edge. The caller registers them.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter bit ZERO_R0   = 1'b1,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  input  logic [ADDR_W-1:0] rd2_addr_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_src_s;
  busy_op_e         op_s [DEPTH];

  // Decide each entry's update; reserve outranks write-back, hardwired r0 never goes busy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      op_s[i] = BSY_HOLD;
      if (ZERO_R0 && (i == 0)) begin
        op_s[i] = BSY_CLEAR;
      end else if (rsv_en_i && (rsv_addr_i == ADDR_W'(i))) begin
        op_s[i] = BSY_SET;
      end else if (wb_en_i && (wb_addr_i == ADDR_W'(i))) begin
        op_s[i] = BSY_CLEAR;
      end else begin
        op_s[i] = BSY_HOLD;
      end
    end
  end

  // Apply the chosen update to form the next busy vector.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      case (op_s[i])
        BSY_SET:   busy_d[i] = 1'b1;
        BSY_CLEAR: busy_d[i] = 1'b0;
        BSY_HOLD:  busy_d[i] = busy_q[i];
        default:   busy_d[i] = busy_q[i];
      endcase
    end
  end

  // Busy-bit storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups; entry 0 is held at 0 in both vectors when ZERO_R0 is set.
  always_comb begin
    if (BYPASS_EN) begin
      busy_src_s = busy_d;
    end else begin
      busy_src_s = busy_q;
    end
    busy1_o = busy_src_s[rd1_addr_i];
    busy2_o = busy_src_s[rd2_addr_i];
  end

endmodule : regbank_scoreboard

// File: rtl/regbank_sb.sv
// regbank_sb -- parametrised two-read / one-write register bank with an
// in-flight write scoreboard for the ID-stage hazard unit.
// Configuration macro: REGBANK_BYPASS_EN. When defined, a read captured on the
// same edge as a write-back to that register returns the new data and the
// post-edge busy bit; otherwise it returns the pre-edge values.
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic [ADDR_W-1:0] i_AddrReg1,
  input  logic [ADDR_W-1:0] i_AddrReg2,
  input  logic              i_ReadEn,
  input  logic [ADDR_W-1:0] i_AddrRegDest,
  input  logic [DATA_W-1:0] i_WriteData,
  input  logic              i_WriteBack,
  input  logic              i_Reserve,
  input  logic [ADDR_W-1:0] i_AddrReserve,
  output logic [DATA_W-1:0] o_Data1,
  output logic [DATA_W-1:0] o_Data2,
  output logic              o_Busy1,
  output logic              o_Busy2,
  output logic              o_Valid
);

  localparam int                DEPTH    = depth_of(ADDR_W);
  localparam logic [DATA_W-1:0] RST_DATA = {DATA_W{RST_BIT}};

`ifdef REGBANK_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic              sb_busy1_s;
  logic              sb_busy2_s;

  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic              busy1_q, busy1_d;
  logic              busy2_q, busy2_d;
  logic              valid_q, valid_d;

  // A write-back lands unless it targets the hardwired zero register.
  always_comb begin
    if (ZERO_R0 && (i_AddrRegDest == '0)) begin
      wr_ok_s = 1'b0;
    end else begin
      wr_ok_s = i_WriteBack;
    end
  end

  // Architectural register storage, one write port.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_DATA;
      end
    end else if (wr_ok_s) begin
      mem_q[i_AddrRegDest] <= i_WriteData;
    end
  end

  regbank_scoreboard #(
    .ADDR_W    (ADDR_W),
    .ZERO_R0   (ZERO_R0),
    .BYPASS_EN (BYPASS_EN)
  ) u_scoreboard (
    .clk_i      (i_CLK),
    .rst_ni     (i_RST_N),
    .wb_en_i    (i_WriteBack),
    .wb_addr_i  (i_AddrRegDest),
    .rsv_en_i   (i_Reserve),
    .rsv_addr_i (i_AddrReserve),
    .rd1_addr_i (i_AddrReg1),
    .rd2_addr_i (i_AddrReg2),
    .busy1_o    (sb_busy1_s),
    .busy2_o    (sb_busy2_s)
  );

  // Read-port data selection: optional forwarding, then the zero-register override.
  always_comb begin
    if (BYPASS_EN && wr_ok_s && (i_AddrRegDest == i_AddrReg1)) begin
      rd1_s = i_WriteData;
    end else begin
      rd1_s = mem_q[i_AddrReg1];
    end
    if (BYPASS_EN && wr_ok_s && (i_AddrRegDest == i_AddrReg2)) begin
      rd2_s = i_WriteData;
    end else begin
      rd2_s = mem_q[i_AddrReg2];
    end
    if (ZERO_R0 && (i_AddrReg1 == '0)) begin
      rd1_s = RST_DATA;
    end else begin
      rd1_s = rd1_s;
    end
    if (ZERO_R0 && (i_AddrReg2 == '0)) begin
      rd2_s = RST_DATA;
    end else begin
      rd2_s = rd2_s;
    end
  end

  // Next state of the read-port registers: capture on i_ReadEn, otherwise hold.
  always_comb begin
    if (i_ReadEn) begin
      data1_d = rd1_s;
      data2_d = rd2_s;
      busy1_d = sb_busy1_s;
      busy2_d = sb_busy2_s;
      valid_d = 1'b1;
    end else begin
      data1_d = data1_q;
      data2_d = data2_q;
      busy1_d = busy1_q;
      busy2_d = busy2_q;
      valid_d = 1'b0;
    end
  end

  // Read-port output registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      data1_q <= RST_DATA;
      data2_q <= RST_DATA;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data1_q <= data1_d;
      data2_q <= data2_d;
      busy1_q <= busy1_d;
      busy2_q <= busy2_d;
      valid_q <= valid_d;
    end
  end

  assign o_Data1 = data1_q;
  assign o_Data2 = data2_q;
  assign o_Busy1 = busy1_q;
  assign o_Busy2 = busy2_q;
  assign o_Valid = valid_q;

endmodule : regbank_sb

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb -- self-checking bench for regbank_sb (8x8 and 16x16 builds).
// Honours REGBANK_BYPASS_EN when choosing expected same-cycle results.
module tb_regbank_sb;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit x 8-entry instance
  logic [2:0] a1, a2, wa, ra;
  logic       re, we, rs;
  logic [7:0] wd;
  logic [7:0] d1, d2;
  logic       b1, b2, v;

  // 16-bit x 16-entry instance
  logic [3:0]  b_a1, b_a2, b_wa, b_ra;
  logic        b_re, b_we, b_rs;
  logic [15:0] b_wd;
  logic [15:0] b_d1, b_d2;
  logic        b_b1, b_b2, b_v;

  regbank_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1'b1)) dut (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_AddrReg1(a1), .i_AddrReg2(a2), .i_ReadEn(re),
    .i_AddrRegDest(wa), .i_WriteData(wd), .i_WriteBack(we),
    .i_Reserve(rs), .i_AddrReserve(ra),
    .o_Data1(d1), .o_Data2(d2), .o_Busy1(b1), .o_Busy2(b2), .o_Valid(v)
  );

  regbank_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1)) dut_w (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_AddrReg1(b_a1), .i_AddrReg2(b_a2), .i_ReadEn(b_re),
    .i_AddrRegDest(b_wa), .i_WriteData(b_wd), .i_WriteBack(b_we),
    .i_Reserve(b_rs), .i_AddrReserve(b_ra),
    .o_Data1(b_d1), .o_Data2(b_d2), .o_Busy1(b_b1), .o_Busy2(b_b2), .o_Valid(b_v)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model (8x8 instance) ----------------
  logic [7:0] m_reg [8];
  bit         m_busy [8];
  logic [7:0] e_d1, e_d2;
  bit         e_b1, e_b2, e_v;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 8'h00;
      m_busy[i] = 1'b0;
    end
    e_d1 = 8'h00; e_d2 = 8'h00; e_b1 = 1'b0; e_b2 = 1'b0; e_v = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (BYP && we && (wa == a)) return wd;
    return m_reg[a];
  endfunction

  function automatic bit m_bsy(input logic [2:0] a);
    if (a == 3'd0) return 1'b0;
    if (BYP && rs && (ra == a)) return 1'b1;
    if (BYP && we && (wa == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (re) begin
      e_d1 = m_read(a1); e_d2 = m_read(a2);
      e_b1 = m_bsy(a1);  e_b2 = m_bsy(a2);
      e_v = 1'b1;
    end else begin
      e_v = 1'b0;
    end
    if (we && (wa != 3'd0)) begin
      m_reg[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (rs && (ra != 3'd0)) m_busy[ra] = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = 3'd0; wd = 8'h00; rs = 1'b0; ra = 3'd0;
    re = 1'b0; a1 = 3'd0; a2 = 3'd0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_d1"}, 32'(d1), 32'(e_d1));
    chk({tag, "_d2"}, 32'(d2), 32'(e_d2));
    chk({tag, "_b1"}, 32'(b1), 32'(e_b1));
    chk({tag, "_b2"}, 32'(b2), 32'(e_b2));
    chk({tag, "_v"},  32'(v),  32'(e_v));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we; logic [2:0] wa; logic [7:0] wd;
    logic       rs; logic [2:0] ra;
    logic       re; logic [2:0] a1; logic [2:0] a2;
    logic [7:0] x_d1; logic [7:0] x_d2; logic x_b1; logic x_b2; logic x_v;
  } vec_t;

  function automatic vec_t mk(
    input logic w, input logic [2:0] wadr, input logic [7:0] wdat,
    input logic r, input logic [2:0] radr,
    input logic rd, input logic [2:0] p1, input logic [2:0] p2,
    input logic [7:0] xd1, input logic [7:0] xd2,
    input logic xb1, input logic xb2, input logic xv);
    vec_t t;
    t.we = w; t.wa = wadr; t.wd = wdat; t.rs = r; t.ra = radr;
    t.re = rd; t.a1 = p1; t.a2 = p2;
    t.x_d1 = xd1; t.x_d2 = xd2; t.x_b1 = xb1; t.x_b2 = xb2; t.x_v = xv;
    return t;
  endfunction

  vec_t tbl [14];

  initial begin
    // table: we wa wd | rs ra | re a1 a2 || d1 d2 b1 b2 v
    tbl[0]  = mk(1'b1, 3'd1, 8'h82, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 3'd2, 8'h83, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd1, 3'd2, 8'h82, 8'h83, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(1'b1, 3'd5, 8'hA0, 1'b0, 3'd0, 1'b1, 3'd5, 3'd5,
                 BYP ? 8'hA0 : 8'h00, BYP ? 8'hA0 : 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd5, 3'd1, 8'hA0, 8'h82, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd4, 3'd4, 8'h00, 8'h00, BYP, BYP, 1'b1);
    tbl[6]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd4, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 1'b1, 3'd4, 3'd4,
                 BYP ? 8'h11 : 8'h00, BYP ? 8'h11 : 8'h00, !BYP, !BYP, 1'b1);
    tbl[8]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd4, 3'd0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 3'd4, 8'h22, 1'b1, 3'd4, 1'b1, 3'd4, 3'd4,
                 BYP ? 8'h22 : 8'h11, BYP ? 8'h22 : 8'h11, BYP, BYP, 1'b1);
    tbl[10] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd4, 3'd4, 8'h22, 8'h22, 1'b1, 1'b1, 1'b1);
    tbl[11] = mk(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd0, 3'd4, 8'h00, 8'h22, 1'b0, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd1, 3'd2, 8'h00, 8'h22, 1'b0, 1'b1, 1'b0);

    // ---- reset state ----
    rst_n = 1'b0;
    idle();
    b_we = 1'b0; b_wa = 4'd0; b_wd = 16'h0000; b_rs = 1'b0; b_ra = 4'd0;
    b_re = 1'b0; b_a1 = 4'd0; b_a2 = 4'd0;
    model_reset();
    #2;
    check_model("reset");
    chk("reset_w_d1", 32'(b_d1), 32'h0);
    chk("reset_w_v",  32'(b_v),  32'h0);
    #6 rst_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 14; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      rs = tbl[i].rs; ra = tbl[i].ra;
      re = tbl[i].re; a1 = tbl[i].a1; a2 = tbl[i].a2;
      step();
      chk($sformatf("vec%0d_d1", i), 32'(d1), 32'(tbl[i].x_d1));
      chk($sformatf("vec%0d_d2", i), 32'(d2), 32'(tbl[i].x_d2));
      chk($sformatf("vec%0d_b1", i), 32'(b1), 32'(tbl[i].x_b1));
      chk($sformatf("vec%0d_b2", i), 32'(b2), 32'(tbl[i].x_b2));
      chk($sformatf("vec%0d_v",  i), 32'(v),  32'(tbl[i].x_v));
    end
    idle();

    // ---- wide instance: R15 write, dual read, hold ----
    b_we = 1'b1; b_wa = 4'd15; b_wd = 16'hBEEF;
    step();
    b_we = 1'b0; b_re = 1'b1; b_a1 = 4'd15; b_a2 = 4'd15;
    step();
    chk("wide_rd_d1", 32'(b_d1), 32'hBEEF);
    chk("wide_rd_d2", 32'(b_d2), 32'hBEEF);
    chk("wide_rd_v",  32'(b_v),  32'h1);
    chk("wide_rd_b1", 32'(b_b1), 32'h0);
    b_re = 1'b0; b_a1 = 4'd1; b_a2 = 4'd2;
    step();
    chk("wide_hold_d1", 32'(b_d1), 32'hBEEF);
    chk("wide_hold_d2", 32'(b_d2), 32'hBEEF);
    chk("wide_hold_v",  32'(b_v),  32'h0);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom_range(0, 1));
      wa = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      rs = ($urandom_range(0, 2) == 0);
      ra = 3'($urandom_range(0, 7));
      re = ($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 1) == 0) ? wa : 3'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 1) == 0) ? ra : 3'($urandom_range(0, 7));
      step();
      check_model($sformatf("rnd%0d", k));
    end
    idle();

    // ---- reset in mid-operation ----
    we = 1'b1; wa = 3'd3; wd = 8'h55;
    step();
    we = 1'b0; re = 1'b1; a1 = 3'd3; a2 = 3'd3;
    step();
    chk("pre_rst_d1", 32'(d1), 32'h55);
    chk("pre_rst_v",  32'(v),  32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_d1", 32'(d1), 32'h0);
    chk("async_rst_d2", 32'(d2), 32'h0);
    chk("async_rst_v",  32'(v),  32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    re = 1'b0;
    step();
    re = 1'b1; a1 = 3'd3; a2 = 3'd3;
    step();
    check_model("post_rst");
    chk("post_rst_r3", 32'(d1), 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_regbank_sb
